d_input_debouncer: RTL and testbench
====================================

# d_input_debouncer

Conditions a raw, asynchronous, possibly bouncing single-bit input into a clean, clock-synchronous level suitable for driving the `d` input of the team's D flip-flop stage. It uses the following chain:
- a two-flop synchronizer;
- a four-state debounce state machine with a stability counter;
- one-cycle rise/fall strobe outputs.

It sits directly upstream of the flip-flop examples. Its `d_clean` output drives `d`, and `rise`/`fall` are available as enables.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized samples at the new level required before `d_clean` changes. Legal range is 2..255.
- `CNT_W`, default 8: stability counter width. Must satisfy 2^`CNT_W` > `STABLE_CYCLES`.

Ports:
- `clk`, input, 1: rising-edge clock for all state.
- `rst_n`, input, 1: reset, asynchronous, active-low. Asserting it immediately forces all state to reset values. Deassertion is taken synchronously to `clk`.
- `d_raw`, input, 1: raw asynchronous data (switch, button, external pin).
- `d_clean`, output, 1: debounced, synchronized level.
- `rise`, output, 1: one-cycle pulse when `d_clean` goes 0→1.
- `fall`, output, 1: one-cycle pulse when `d_clean` goes 1→0.
- `busy`, output, 1: high while a candidate transition is being qualified.

## Operation
- **Synchronizer:** `s1` <= `d_raw`, then `s2` <= `s1`. Only `s2` is used downstream.
- **FSM states:**
  - `IDLE_LOW`: `d_clean`=0.
  - `WAIT_HIGH`: qualifying a 0→1 transition.
  - `IDLE_HIGH`: `d_clean`=1.
  - `WAIT_LOW`: qualifying a 1→0 transition.
- **`IDLE_LOW` transitions:**
  - `s2`=1: go to `WAIT_HIGH`, `cnt`<=1.
  - Otherwise: stay, `cnt`<=0.
- **`WAIT_HIGH` transitions:**
  - `s2`=0: abort to `IDLE_LOW`, `cnt`<=0, no output change.
  - `s2`=1 and `cnt`==`STABLE_CYCLES`-1: commit. Go to `IDLE_HIGH`, `d_clean`<=1, `rise`<=1, `cnt`<=0.
  - `s2`=1 otherwise: `cnt`<=`cnt`+1.
- **`IDLE_HIGH` / `WAIT_LOW`:** mirror of the above with polarity inverted. Commit sets `d_clean`<=0 and `fall`<=1.
- **Strobes:** `rise` and `fall` are registered and high for exactly one cycle. They are never high simultaneously.
- **`busy`:** registered state decode, 1 in `WAIT_HIGH` or `WAIT_LOW`.
- **Counter:** never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible.
- **Reset values:**
  - `s1`=`s2`=0, state=`IDLE_LOW`, `cnt`=0.
  - `d_clean`=0, `rise`=0, `fall`=0, `busy`=0.
- **Reset mid-qualification:** the pending transition is discarded and no strobe is emitted. After release, if `d_raw` is still 1, a full qualification restarts from `IDLE_LOW`.
- **Input held high through reset release:** produces a normal `rise` after full latency. There is no implicit "already high" state.

## Timing
- Let E0 be the first `clk` rising edge that samples `d_raw`=1, with `d_raw` held stable afterward.
  - `s2`=1 after E1.
  - FSM enters `WAIT_HIGH` at E2.
  - Commit at E(1+`STABLE_CYCLES`).
  - `d_clean`, `rise` and `busy`=0 all become visible after that edge.
- **Latency** from first sampling edge to `d_clean` change is `STABLE_CYCLES`+1 edges. The default is 5 edges.
- **`busy`:** high from after E2 through the commit edge. That is `STABLE_CYCLES`-1 cycles.
- **Glitch rejection:** a pulse seen by `s2` for fewer than `STABLE_CYCLES` consecutive samples never changes `d_clean`.
- **Abort and re-entry:** an abort in `WAIT_*` returns to `IDLE_*` for at least one cycle. A new candidate then re-enters `WAIT_*` with `cnt`=1 at the next edge.
- **Back-to-back transitions:** minimum spacing between a `rise` and the following `fall` is `STABLE_CYCLES` cycles.
- **Metastability:** `d_raw` may change at any time relative to `clk`. Only `s1` may go metastable.

## Test plan
- **Reset:** `rst_n`=0 with `d_raw` toggling.
  - Required: all outputs 0 and state `IDLE_LOW`.
  - Assert `rst_n` mid-cycle and check outputs clear without a clock edge.
- **Clean rise:** `STABLE_CYCLES`=4, `d_raw` 0→1 held for 20 cycles.
  - `d_clean`=1 after the 5th edge following the first sampling edge.
  - `rise`=1 for exactly that one cycle.
  - `busy`=1 for the 3 cycles before the commit.
- **Bounce rejection:** `d_raw` high for 2 cycles, low 1, high 3, low 1, then high for 10.
  - No `rise` during the bounce.
  - A single `rise` occurs 5 edges after the start of the final stable high.
- **Clean fall:** from `IDLE_HIGH`, `d_raw` 1→0 held.
  - `d_clean`=0 and `fall` pulses once after 5 edges.
  - `rise` stays 0 throughout.
- **Reset mid-qualification:** `d_raw`=1, assert `rst_n`=0 while `busy`=1, release with `d_raw` still 1.
  - No `rise` before reset.
  - After release, `rise` occurs `STABLE_CYCLES`+1 edges after the first post-reset sampling edge.
- **Minimum-length pulse:** `STABLE_CYCLES`=2, 2-cycle and 1-cycle synchronized highs.
  - The 2-cycle high produces `rise` and then `fall`.
  - The 1-cycle high produces nothing.

Source files
------------

// File: rtl/d_input_debouncer.sv
`default_nettype none
// d_input_debouncer: two-flop synchronizer, four-state debounce FSM with a
// stability counter, and registered one-cycle rise/fall strobes.
module d_input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic d_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 255) ||
      ((2 ** CNT_W) <= STABLE_CYCLES)) begin : g_param_check
    $error("d_input_debouncer: illegal STABLE_CYCLES/CNT_W combination");
  end

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clean_nxt, rise_nxt, fall_nxt;

  // Only s1 may go metastable; everything downstream sees s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    clean_nxt = d_clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          clean_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          clean_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
      end
    endcase
  end

  // busy is the registered decode of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      d_clean <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      d_clean <= clean_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      busy    <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_input_debouncer.sv
`default_nettype none
// Bench for d_input_debouncer: two instances (STABLE_CYCLES 4 and 2) driven by the
// same input, checked against a run-length reference model plus directed latency checks.
module tb_d_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_raw = 1'b0;
  logic [1:0] clean, rise_o, fall_o, busy_o;

  d_input_debouncer #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .d_raw(d_raw),
    .d_clean(clean[0]), .rise(rise_o[0]), .fall(fall_o[0]), .busy(busy_o[0])
  );

  d_input_debouncer #(.STABLE_CYCLES(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .d_raw(d_raw),
    .d_clean(clean[1]), .rise(rise_o[1]), .fall(fall_o[1]), .busy(busy_o[1])
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: d_clean flips once the input (two clocks late) has differed
  // from it for STABLE_CYCLES consecutive samples.
  int st [2] = '{4, 2};
  bit m_s1, m_s2;
  bit m_clean [2];
  bit m_rise  [2];
  bit m_fall  [2];
  int m_run   [2];

  function automatic void model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_clean[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_run[i]  = (m_s2 != m_clean[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] == st[i]) begin
        m_clean[i] = m_s2;
        m_rise[i]  = m_s2;
        m_fall[i]  = !m_s2;
        m_run[i]   = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = d_raw;
  endfunction

  // Directed statistics, edge-indexed from the last clr_stats().
  int k;
  int nrise [2], nfall [2], nbusy [2], rise_at [2], fall_at [2];

  task automatic clr_stats();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      nrise[i] = 0; nfall[i] = 0; nbusy[i] = 0; rise_at[i] = 0; fall_at[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    k++;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_inst%0d", i),
            {28'd0, clean[i], rise_o[i], fall_o[i], busy_o[i]},
            {28'd0, m_clean[i], m_rise[i], m_fall[i], m_run[i] != 0});
      if (rise_o[i] === 1'b1) begin
        nrise[i]++;
        if (rise_at[i] == 0) rise_at[i] = k;
      end
      if (fall_o[i] === 1'b1) begin
        nfall[i]++;
        if (fall_at[i] == 0) fall_at[i] = k;
      end
      if (busy_o[i] === 1'b1) nbusy[i]++;
    end
  endtask

  task automatic run(input int n, input logic v);
    d_raw = v;
    for (int j = 0; j < n; j++) tick();
  endtask

  // Asserts reset between edges and checks outputs clear with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(tag, {28'd0, clean, rise_o, fall_o, busy_o} & 32'hFF, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clr_stats();

    // Reset held with a toggling input.
    for (int j = 0; j < 6; j++) begin
      d_raw = j[0];
      tick();
    end
    check("reset_outs", {24'd0, clean, rise_o, fall_o, busy_o}, 32'd0);
    d_raw = 1'b0;
    rst_n = 1'b1;
    run(4, 1'b0);

    // Clean rise: commit 5 edges after the sampling edge (k == 6).
    clr_stats();
    run(20, 1'b1);
    check("rise_count0", nrise[0], 1);
    check("rise_edge0",  rise_at[0], 6);
    check("busy_cycles0", nbusy[0], 3);
    check("clean_high0", clean[0], 1);
    check("rise_edge1",  rise_at[1], 4);

    // Clean fall.
    clr_stats();
    run(20, 1'b0);
    check("fall_count0", nfall[0], 1);
    check("fall_edge0",  fall_at[0], 6);
    check("no_rise_in_fall0", nrise[0], 0);

    // Bounce rejection.
    clr_stats();
    run(2, 1'b1); run(1, 1'b0); run(3, 1'b1); run(1, 1'b0);
    check("bounce_no_rise0", nrise[0], 0);
    clr_stats();
    run(10, 1'b1);
    check("bounce_rise_count0", nrise[0], 1);
    check("bounce_rise_edge0",  rise_at[0], 6);

    // Reset while qualifying a rise.
    run(12, 1'b0);
    clr_stats();
    d_raw = 1'b1;
    for (int j = 0; j < 10 && busy_o[0] !== 1'b1; j++) tick();
    check("busy_reached0", busy_o[0], 1);
    check("no_rise_before_rst0", nrise[0], 0);
    async_reset("midqual_reset_outs");
    tick();
    tick();
    rst_n = 1'b1;
    clr_stats();
    run(12, 1'b1);
    check("post_rst_rise_count0", nrise[0], 1);
    check("post_rst_rise_edge0",  rise_at[0], 6);

    // Minimum-length pulses on the STABLE_CYCLES=2 instance.
    run(12, 1'b0);
    clr_stats();
    run(2, 1'b1);
    run(12, 1'b0);
    check("pulse2_rise1", nrise[1], 1);
    check("pulse2_fall1", nfall[1], 1);
    check("pulse2_no_rise0", nrise[0], 0);
    clr_stats();
    run(1, 1'b1);
    run(12, 1'b0);
    check("pulse1_rise1", nrise[1], 0);
    check("pulse1_fall1", nfall[1], 0);

    // Randomized segments with occasional asynchronous resets.
    for (int n = 0; n < 300; n++) begin
      run($urandom_range(1, 8), 1'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_reset_outs");
        tick();
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
